// File: rtl/spi_xfer_sequencer_if.sv
// spi_xfer_sequencer_if: command, response and SPI-master handshake bundle for spi_xfer_sequencer
interface spi_xfer_sequencer_if #(
    parameter int DWIDTH = 8,
    parameter int IDW = 1
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DWIDTH-1:0] cmd_data;
    logic [IDW-1:0]    cmd_id;
    logic              Request;
    logic [31:0]       ID;
    logic [DWIDTH-1:0] Data;
    logic              Done;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_err;
    modport master (
        input  cmd_valid, cmd_data, cmd_id, Done,
        output cmd_ready, Request, ID, Data, rsp_valid, rsp_id, rsp_err
    );
    modport slave (
        output cmd_valid, cmd_data, cmd_id, Done,
        input  cmd_ready, Request, ID, Data, rsp_valid, rsp_id, rsp_err
    );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: queues SPI transfer commands and sequences them through the master's Request/Done handshake; define SPI_XFER_TIMEOUT_EN for the Done watchdog
module spi_xfer_sequencer #(
    parameter int DWIDTH = 8,
    parameter int NUMSLAVES = 1,
    parameter int DEPTH = 4,
    parameter int IDLE_GAP = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                   mainclk,
    input  logic                   reset,
    spi_xfer_sequencer_if.master   bus,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);
    localparam int IDW = NUMSLAVES > 1 ? $clog2(NUMSLAVES) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(IDLE_GAP + 1);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, GAP} state_t;
    state_t                 state_q, state_d;
    logic [IDW+DWIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]          wr_q, rd_q;
    logic [AW:0]            level_q, level_d;
    logic [DWIDTH-1:0]      data_q, data_d;
    logic [IDW-1:0]         id_q, id_d, rsp_id_q, rsp_id_d;
    logic                   req_q, req_d, rsp_valid_q, rsp_valid_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic                   sync_q, done_s_q, done_d_q;
    logic                   push, pop, rise;
`ifdef SPI_XFER_TIMEOUT_EN
    logic [31:0]            wdog_q, wdog_d;
    logic                   rsp_err_q, rsp_err_d;
    assign bus.rsp_err = rsp_err_q;
`else
    logic                   unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign bus.rsp_err = 1'b0;
`endif
    assign push = bus.cmd_valid && bus.cmd_ready;
    assign pop = state_q == ISSUE;
    assign rise = done_s_q && !done_d_q;
    assign level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    assign bus.cmd_ready = level_q != (AW+1)'(DEPTH);
    assign bus.Request = req_q;
    assign bus.ID = {{(32-IDW){1'b0}}, id_q};
    assign bus.Data = data_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id = rsp_id_q;
    assign busy = state_q != IDLE || level_q != '0;
    assign level = level_q;

    // command storage, no reset needed since occupancy is tracked by the pointers
    always_ff @(posedge mainclk) begin
        if (push) mem_q[wr_q] <= {bus.cmd_id, bus.cmd_data};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge mainclk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
            level_q <= '0;
        end else begin
            wr_q <= wr_q + AW'(push);
            rd_q <= rd_q + AW'(pop);
            level_q <= level_d;
        end
    end

    // Done synchronizer plus delayed copy for rising-edge detection
    always_ff @(posedge mainclk) begin
        if (reset) begin
            sync_q <= 1'b0;
            done_s_q <= 1'b0;
            done_d_q <= 1'b0;
        end else begin
            sync_q <= bus.Done;
            done_s_q <= sync_q;
            done_d_q <= done_s_q;
        end
    end

    // FSM state and registered master/response outputs
    always_ff @(posedge mainclk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q <= '0;
            id_q <= '0;
            req_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q <= '0;
            gap_q <= '0;
`ifdef SPI_XFER_TIMEOUT_EN
            wdog_q <= '0;
            rsp_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q <= data_d;
            id_q <= id_d;
            req_q <= req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q <= rsp_id_d;
            gap_q <= gap_d;
`ifdef SPI_XFER_TIMEOUT_EN
            wdog_q <= wdog_d;
            rsp_err_q <= rsp_err_d;
`endif
        end
    end

    // next-state logic; the Done edge is only honoured in WAIT_HIGH so stale edges are ignored
    always_comb begin
        state_d = state_q;
        data_d = data_q;
        id_d = id_q;
        req_d = req_q;
        rsp_valid_d = 1'b0;
        rsp_id_d = rsp_id_q;
        gap_d = gap_q;
`ifdef SPI_XFER_TIMEOUT_EN
        wdog_d = wdog_q;
        rsp_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: state_d = level_q != '0 ? ISSUE : IDLE;
            ISSUE: begin
                {id_d, data_d} = mem_q[rd_q];
                req_d = 1'b1;
                state_d = WAIT_LOW;
`ifdef SPI_XFER_TIMEOUT_EN
                wdog_d = '0;
`endif
            end
            WAIT_LOW: state_d = done_s_q ? WAIT_LOW : WAIT_HIGH;
            WAIT_HIGH: begin
                if (rise) begin
                    req_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d = id_q;
                    state_d = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q == GW'(IDLE_GAP - 1) ? '0 : gap_q + 1'b1;
                state_d = gap_q == GW'(IDLE_GAP - 1) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
`ifdef SPI_XFER_TIMEOUT_EN
        if ((state_q == WAIT_LOW || state_q == WAIT_HIGH) && state_d != GAP) begin
            wdog_d = wdog_q + 1'b1;
            if (wdog_q == 32'(TIMEOUT - 1)) begin
                req_d = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_err_d = 1'b1;
                rsp_id_d = id_q;
                state_d = GAP;
            end
        end
`endif
    end
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb_spi_xfer_sequencer: directed scoreboard bench for spi_xfer_sequencer with a Done-driving master model
module tb_spi_xfer_sequencer;
    localparam int TO = 50;
    typedef struct packed {
        logic [2:0] id;
        logic [7:0] data;
        logic       err;
    } item_t;

    logic       mainclk = 1'b0;
    logic       reset;
    logic       busy;
    logic [2:0] level;
    logic       auto, stall, m_done, man_done;
    int         done_delay;
    int         cyc = 0;
    int         acc_cyc, rise_cyc, done_cyc, rsp_cyc;
    int         last_fall = -1;
    int         last_gap = -1;
    int         n_checks = 0;
    int         n_fail = 0;
    logic       req_prev = 1'b0;
    logic       rsp_prev = 1'b0;
    item_t      exp_q[$];
    item_t      iss_q[$];
    item_t      cur = '0;
    item_t      e;

    spi_xfer_sequencer_if #(.DWIDTH(8), .IDW(3)) bus ();

    spi_xfer_sequencer #(
        .DWIDTH(8), .NUMSLAVES(8), .DEPTH(4), .IDLE_GAP(4), .TIMEOUT(TO)
    ) dut (
        .mainclk(mainclk), .reset(reset), .bus(bus), .busy(busy), .level(level)
    );

    assign bus.Done = auto ? m_done : man_done;

    initial forever #5 mainclk = ~mainclk;
    initial forever begin
        @(posedge mainclk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] id, input logic [7:0] d, input logic err);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_id = id;
        bus.cmd_data = d;
        while (!bus.cmd_ready && n < 200) begin
            @(posedge mainclk);
            #1;
            n++;
        end
        check("push_ready", bus.cmd_ready, 1);
        @(posedge mainclk);
        exp_q.push_back('{id: id, data: d, err: err});
        iss_q.push_back('{id: id, data: d, err: err});
        #1;
        acc_cyc = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < limit) begin
            @(posedge mainclk);
            #1;
            n++;
        end
        check("drain_busy", busy, 0);
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        m_done = 1'b1;
        forever begin
            @(posedge mainclk);
            #1;
            if (auto && bus.Request && m_done) begin
                repeat (2) @(posedge mainclk);
                #1 m_done = 1'b0;
                for (int i = 0; i < 2000 && stall; i++) @(posedge mainclk);
                repeat (done_delay) @(posedge mainclk);
                #1 m_done = 1'b1;
                done_cyc = cyc;
                for (int i = 0; i < 10 && bus.Request; i++) begin
                    @(posedge mainclk);
                    #1;
                end
            end
        end
    end

    initial forever begin
        @(negedge mainclk);
        if (!reset) begin
            if (bus.Request && !req_prev) begin
                rise_cyc = cyc;
                if (last_fall >= 0) last_gap = cyc - last_fall;
                if (iss_q.size() == 0) check("unexpected_req", bus.Request, 0);
                else cur = iss_q.pop_front();
            end
            if (!bus.Request && req_prev) last_fall = cyc;
            if (bus.Request) begin
                check("data_hold", bus.Data, cur.data);
                check("id_hold", bus.ID, 32'(cur.id));
            end
            if (bus.rsp_valid) begin
                rsp_cyc = cyc;
                check("rsp_pulse", rsp_prev, 0);
                check("req_fall_with_rsp", {bus.Request, req_prev}, 2'b01);
                if (exp_q.size() == 0) check("unexpected_rsp", bus.rsp_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    check("rsp_id", bus.rsp_id, e.id);
                    check("rsp_err", bus.rsp_err, e.err);
                    if (!e.err) check("done_to_rsp", cyc - done_cyc, 3);
                end
            end
        end
        req_prev = bus.Request;
        rsp_prev = bus.rsp_valid;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data = '0;
        bus.cmd_id = '0;
        auto = 1'b1;
        stall = 1'b0;
        man_done = 1'b1;
        done_delay = 20;
        repeat (3) @(posedge mainclk);
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_request", bus.Request, 0);
        check("rst_id", bus.ID, 0);
        check("rst_data", bus.Data, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        reset = 1'b0;
        @(posedge mainclk);
        #1;
        push(3'd0, 8'hA5, 1'b0);
        drain(200);
        check("req_latency", rise_cyc - acc_cyc, 2);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) push(3'(i), 8'(8'h10 + i), 1'b0);
        check("fill_level", level, 4);
        check("fill_ready", bus.cmd_ready, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_id = 3'd5;
        bus.cmd_data = 8'hFF;
        repeat (3) @(posedge mainclk);
        #1;
        check("fill_refused", level, 4);
        bus.cmd_valid = 1'b0;
        stall = 1'b0;
        drain(600);
        push(3'd1, 8'h5A, 1'b0);
        push(3'd2, 8'hC3, 1'b0);
        drain(300);
        check("req_gap", last_gap, 6);
        push(3'd3, 8'h77, 1'b0);
        @(posedge mainclk);
        #1;
        push(3'd4, 8'h88, 1'b0);
        check("pushpop_level", level, 1);
        check("pushpop_request", bus.Request, 1);
        drain(300);
        stall = 1'b1;
        push(3'd5, 8'h11, 1'b0);
        push(3'd6, 8'h22, 1'b0);
        push(3'd7, 8'h33, 1'b0);
        repeat (3) @(posedge mainclk);
        #1;
        check("pre_reset_level", level, 2);
        check("pre_reset_request", bus.Request, 1);
        reset = 1'b1;
        exp_q.delete();
        iss_q.delete();
        @(posedge mainclk);
        #1;
        check("reset_req_drop", bus.Request, 0);
        repeat (2) @(posedge mainclk);
        #1;
        reset = 1'b0;
        last_fall = -1;
        check("post_reset_level", level, 0);
        check("post_reset_ready", bus.cmd_ready, 1);
        check("post_reset_request", bus.Request, 0);
        stall = 1'b0;
        repeat (40) @(posedge mainclk);
        #1;
        check("post_reset_busy", busy, 0);
`ifdef SPI_XFER_TIMEOUT_EN
        auto = 1'b0;
        man_done = 1'b1;
        push(3'd6, 8'h3C, 1'b1);
        n = 0;
        while (!bus.Request && n < 20) begin
            @(posedge mainclk);
            #1;
            n++;
        end
        check("to_request", bus.Request, 1);
        @(posedge mainclk);
        #1;
        man_done = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge mainclk);
            #1;
            n++;
        end
        check("to_pending", exp_q.size(), 0);
        check("to_latency", rsp_cyc - rise_cyc, TO);
        man_done = 1'b1;
        repeat (15) @(posedge mainclk);
        #1;
        check("to_late_done", busy, 0);
        auto = 1'b1;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
